// File: rtl/tlul_pkg.sv
// Minimal TL-UL request/response types used by the host arbiter and its bench.
package tlul_pkg;

    localparam logic [2:0] OpGet           = 3'h4;
    localparam logic [2:0] OpAccessAck     = 3'h0;
    localparam logic [2:0] OpAccessAckData = 3'h1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

    localparam tl_d2h_t TL_D2H_DEFAULT = '{
        d_valid:  1'b0,
        d_opcode: OpAccessAck,
        d_param:  3'h0,
        d_size:   2'h0,
        d_source: 8'h0,
        d_sink:   1'b0,
        d_data:   32'h0,
        d_error:  1'b0,
        a_ready:  1'b1
    };

endpackage

// File: rtl/tlul_host_arb2.sv
// Two-to-one TL-UL host arbiter: round-robin A grant held until handshake, in-order tag FIFO
// steering D responses. Define TLUL_HOST_ARB_DATA_PRIO_EN to give h1 (data) fixed priority.
module tlul_host_arb2
    import tlul_pkg::*;
#(
    parameter int unsigned Depth = 2,
    parameter int unsigned CntW  = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  tl_h2d_t         tl_h0_i,
    output tl_d2h_t         tl_h0_o,
    input  tl_h2d_t         tl_h1_i,
    output tl_d2h_t         tl_h1_o,
    output tl_h2d_t         tl_d_o,
    input  tl_d2h_t         tl_d_i,
    output logic [CntW-1:0] outstanding_o,
    output logic            unexp_rsp_o
);

    localparam int unsigned     PtrW    = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [CntW-1:0] CntMax  = CntW'(Depth);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(Depth - 1);

    logic [Depth-1:0] tags_q, tags_d;
    logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             last_q, last_d;
    logic             lock_q, lock_d;
    logic             lock_id_q, lock_id_d;
    logic             unexp_q, unexp_d;

    logic gnt_id, gnt_valid, a_open, fifo_empty, head_id, push, pop;

    always_comb begin
        if (lock_q) begin
            gnt_id = lock_id_q;
        end else if (tl_h0_i.a_valid && tl_h1_i.a_valid) begin
`ifdef TLUL_HOST_ARB_DATA_PRIO_EN
            gnt_id = 1'b1;
`else
            gnt_id = ~last_q;
`endif
        end else begin
            gnt_id = tl_h1_i.a_valid;
        end
        gnt_valid  = gnt_id ? tl_h1_i.a_valid : tl_h0_i.a_valid;
        // Reset gating keeps the device port quiet while rst_ni is held low.
        a_open     = rst_ni && (count_q < CntMax);
        fifo_empty = (count_q == '0);
        head_id    = tags_q[rptr_q];
    end

    always_comb begin
        tl_d_o         = gnt_id ? tl_h1_i : tl_h0_i;
        tl_d_o.a_valid = gnt_valid && a_open;
        tl_d_o.d_ready = fifo_empty ? 1'b1 : (head_id ? tl_h1_i.d_ready : tl_h0_i.d_ready);

        tl_h0_o = TL_D2H_DEFAULT;
        tl_h1_o = TL_D2H_DEFAULT;
        if (!fifo_empty) begin
            if (head_id) begin
                tl_h1_o = tl_d_i;
            end else begin
                tl_h0_o = tl_d_i;
            end
        end
        tl_h0_o.a_ready = !gnt_id && a_open && tl_d_i.a_ready;
        tl_h1_o.a_ready = gnt_id && a_open && tl_d_i.a_ready;
    end

    assign push = tl_d_o.a_valid && tl_d_i.a_ready;
    // A beat seen while empty is never matched, even if a push lands in the same cycle.
    assign pop  = !fifo_empty && tl_d_i.d_valid && tl_d_o.d_ready;

    always_comb begin
        tags_d    = tags_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;
        last_d    = last_q;
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        unexp_d   = unexp_q | (fifo_empty & tl_d_i.d_valid);

        if (push) begin
            tags_d[wptr_q] = gnt_id;
            wptr_d         = (wptr_q == PtrLast) ? '0 : wptr_q + 1'b1;
            last_d         = gnt_id;
        end
        if (pop) begin
            rptr_d = (rptr_q == PtrLast) ? '0 : rptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (push) begin
            lock_d = 1'b0;
        end else if (gnt_valid) begin
            lock_d    = 1'b1;
            lock_id_d = gnt_id;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tags_q    <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            last_q    <= 1'b1;
            lock_q    <= 1'b0;
            lock_id_q <= 1'b0;
            unexp_q   <= 1'b0;
        end else begin
            tags_q    <= tags_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            last_q    <= last_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            unexp_q   <= unexp_d;
        end
    end

    assign outstanding_o = count_q;
    assign unexp_rsp_o   = unexp_q;

endmodule

// File: tb/tb_tlul_host_arb2.sv
// Bench for tlul_host_arb2: directed scenarios plus a randomized run checked against a
// queue-based model of the grant, FIFO-ordering and response-routing rules.
module tb_tlul_host_arb2;
    import tlul_pkg::*;

    localparam int Depth = 2;
    localparam int CntW  = $clog2(Depth + 1);

    logic            clk_i  = 1'b0;
    logic            rst_ni = 1'b0;
    tl_h2d_t         tl_h0_i, tl_h1_i, tl_d_o;
    tl_d2h_t         tl_h0_o, tl_h1_o, tl_d_i;
    logic [CntW-1:0] outstanding_o;
    logic            unexp_rsp_o;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    tlul_host_arb2 #(.Depth(Depth)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .tl_h0_i       (tl_h0_i),
        .tl_h0_o       (tl_h0_o),
        .tl_h1_i       (tl_h1_i),
        .tl_h1_o       (tl_h1_o),
        .tl_d_o        (tl_d_o),
        .tl_d_i        (tl_d_i),
        .outstanding_o (outstanding_o),
        .unexp_rsp_o   (unexp_rsp_o)
    );

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        tl_h0_i = '0;
        tl_h0_i.d_ready = 1'b1;
        tl_h1_i = '0;
        tl_h1_i.d_ready = 1'b1;
        tl_d_i = '0;
        tl_d_i.a_ready = 1'b1;
    endtask

    function automatic tl_h2d_t req(input logic [31:0] addr, input logic [7:0] src);
        tl_h2d_t r = '0;
        r.a_valid   = 1'b1;
        r.a_opcode  = OpGet;
        r.a_size    = 2'd2;
        r.a_source  = src;
        r.a_address = addr;
        r.a_mask    = 4'hf;
        r.d_ready   = 1'b1;
        return r;
    endfunction

    function automatic tl_d2h_t rsp(input logic [31:0] data);
        tl_d2h_t r = '0;
        r.d_valid  = 1'b1;
        r.d_opcode = OpAccessAckData;
        r.d_size   = 2'd2;
        r.d_data   = data;
        r.a_ready  = 1'b1;
        return r;
    endfunction

    task automatic do_reset();
        idle();
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_ni  = 1'b0;
        tl_h0_i = req(32'h40, 8'd0);
        tl_h1_i = req(32'h44, 8'd1);
        tl_d_i  = rsp(32'h77);
        #2;
        checks++; if (tl_d_o.a_valid !== 1'b0) begin errors++; $display("FAIL reset_avalid: got %0b exp 0", tl_d_o.a_valid); end
        checks++; if (tl_h0_o.a_ready !== 1'b0) begin errors++; $display("FAIL reset_h0_aready: got %0b exp 0", tl_h0_o.a_ready); end
        checks++; if (tl_h1_o.a_ready !== 1'b0) begin errors++; $display("FAIL reset_h1_aready: got %0b exp 0", tl_h1_o.a_ready); end
        checks++; if (tl_d_o.d_ready !== 1'b1) begin errors++; $display("FAIL reset_dready: got %0b exp 1", tl_d_o.d_ready); end
        checks++; if (tl_h0_o.d_valid !== 1'b0) begin errors++; $display("FAIL reset_h0_dvalid: got %0b exp 0", tl_h0_o.d_valid); end
        checks++; if (tl_h1_o.d_valid !== 1'b0) begin errors++; $display("FAIL reset_h1_dvalid: got %0b exp 0", tl_h1_o.d_valid); end
        step();
        checks++; if (outstanding_o !== '0) begin errors++; $display("FAIL reset_outstanding: got %0d exp 0", outstanding_o); end
        checks++; if (unexp_rsp_o !== 1'b0) begin errors++; $display("FAIL reset_unexp: got %0b exp 0", unexp_rsp_o); end
        idle();
        rst_ni = 1'b1;
        #1;
    endtask

    task automatic test_single_host();
        do_reset();
        tl_h0_i = req(32'h80, 8'd0);
        #1;
        checks++; if (tl_d_o.a_valid !== 1'b1) begin errors++; $display("FAIL single_avalid: got %0b exp 1", tl_d_o.a_valid); end
        checks++; if (tl_d_o.a_address !== 32'h80) begin errors++; $display("FAIL single_addr: got %0h exp 80", tl_d_o.a_address); end
        checks++; if (tl_h0_o.a_ready !== 1'b1) begin errors++; $display("FAIL single_h0_aready: got %0b exp 1", tl_h0_o.a_ready); end
        checks++; if (outstanding_o !== 2'd0) begin errors++; $display("FAIL single_out0: got %0d exp 0", outstanding_o); end
        step();
        idle();
        tl_d_i = rsp(32'h0);
        #1;
        checks++; if (outstanding_o !== 2'd1) begin errors++; $display("FAIL single_out1: got %0d exp 1", outstanding_o); end
        checks++; if (tl_h0_o.d_valid !== 1'b1) begin errors++; $display("FAIL single_h0_dvalid: got %0b exp 1", tl_h0_o.d_valid); end
        checks++; if (tl_h0_o.d_opcode !== OpAccessAckData) begin errors++; $display("FAIL single_h0_op: got %0h exp %0h", tl_h0_o.d_opcode, OpAccessAckData); end
        checks++; if (tl_h1_o.d_valid !== 1'b0) begin errors++; $display("FAIL single_h1_dvalid: got %0b exp 0", tl_h1_o.d_valid); end
        step();
        idle();
        #1;
        checks++; if (outstanding_o !== 2'd0) begin errors++; $display("FAIL single_out2: got %0d exp 0", outstanding_o); end
        checks++; if (unexp_rsp_o !== 1'b0) begin errors++; $display("FAIL single_unexp: got %0b exp 0", unexp_rsp_o); end
    endtask

    task automatic test_contention();
        int exp_g[4];
`ifdef TLUL_HOST_ARB_DATA_PRIO_EN
        exp_g = '{1, 1, 1, 1};
`else
        exp_g = '{0, 1, 0, 1};
`endif
        do_reset();
        for (int k = 0; k < 4; k++) begin
            tl_h0_i = req(32'h200 + 32'(k * 4), 8'd0);
            tl_h1_i = req(32'h2000 + 32'(k * 4), 8'd1);
            if (k > 0) tl_d_i = rsp(32'(k));
            #1;
            checks++; if (tl_d_o.a_valid !== 1'b1) begin errors++; $display("FAIL contend_avalid[%0d]: got %0b exp 1", k, tl_d_o.a_valid); end
            checks++; if (tl_d_o.a_source !== 8'(exp_g[k])) begin errors++; $display("FAIL contend_grant[%0d]: got %0d exp %0d", k, tl_d_o.a_source, exp_g[k]); end
            if (k > 0) begin
                checks++; if (tl_h0_o.d_valid !== (exp_g[k-1] == 0)) begin errors++; $display("FAIL contend_route[%0d]: got %0b exp %0b", k, tl_h0_o.d_valid, exp_g[k-1] == 0); end
            end
            step();
        end
        idle();
        tl_d_i = rsp(32'h4);
        #1;
        checks++; if (tl_h1_o.d_valid !== (exp_g[3] == 1)) begin errors++; $display("FAIL contend_route_last: got %0b exp %0b", tl_h1_o.d_valid, exp_g[3] == 1); end
        step();
        idle();
        #1;
        checks++; if (outstanding_o !== 2'd0) begin errors++; $display("FAIL contend_out: got %0d exp 0", outstanding_o); end
    endtask

    task automatic test_stall_lock();
        do_reset();
        tl_h0_i = req(32'h80, 8'd0);
        step();
        idle();
        tl_d_i = rsp(32'h0);
        step();
        idle();
        tl_d_i.a_ready = 1'b0;
        tl_h0_i = req(32'h100, 8'd0);
        for (int k = 0; k < 3; k++) begin
            if (k >= 1) tl_h1_i = req(32'h1100, 8'd1);
            #1;
            checks++; if (tl_d_o.a_address !== 32'h100) begin errors++; $display("FAIL stall_addr[%0d]: got %0h exp 100", k, tl_d_o.a_address); end
            checks++; if (tl_h1_o.a_ready !== 1'b0) begin errors++; $display("FAIL stall_h1_aready[%0d]: got %0b exp 0", k, tl_h1_o.a_ready); end
            step();
        end
        tl_d_i.a_ready = 1'b1;
        #1;
        checks++; if (tl_d_o.a_address !== 32'h100) begin errors++; $display("FAIL stall_hs_addr: got %0h exp 100", tl_d_o.a_address); end
        checks++; if (tl_h0_o.a_ready !== 1'b1) begin errors++; $display("FAIL stall_hs_h0_aready: got %0b exp 1", tl_h0_o.a_ready); end
        step();
        tl_h0_i = '0;
        tl_h0_i.d_ready = 1'b1;
        #1;
        checks++; if (tl_d_o.a_address !== 32'h1100) begin errors++; $display("FAIL stall_next_addr: got %0h exp 1100", tl_d_o.a_address); end
        checks++; if (tl_h1_o.a_ready !== 1'b1) begin errors++; $display("FAIL stall_next_h1_aready: got %0b exp 1", tl_h1_o.a_ready); end
        step();
        checks++; if (outstanding_o !== 2'd2) begin errors++; $display("FAIL stall_out: got %0d exp 2", outstanding_o); end
    endtask

    task automatic test_full();
        do_reset();
        tl_h1_i = req(32'h1000, 8'd1);
        step();
        tl_h1_i = '0;
        tl_h1_i.d_ready = 1'b1;
        tl_h0_i = req(32'h200, 8'd0);
        step();
        tl_h0_i = req(32'h300, 8'd0);
        #1;
        checks++; if (outstanding_o !== 2'd2) begin errors++; $display("FAIL full_out: got %0d exp 2", outstanding_o); end
        checks++; if (tl_h0_o.a_ready !== 1'b0) begin errors++; $display("FAIL full_h0_aready: got %0b exp 0", tl_h0_o.a_ready); end
        checks++; if (tl_d_o.a_valid !== 1'b0) begin errors++; $display("FAIL full_avalid: got %0b exp 0", tl_d_o.a_valid); end
        step();
        tl_d_i = rsp(32'h11);
        #1;
        checks++; if (tl_h1_o.d_valid !== 1'b1) begin errors++; $display("FAIL full_pop_h1_dvalid: got %0b exp 1", tl_h1_o.d_valid); end
        checks++; if (tl_h1_o.d_data !== 32'h11) begin errors++; $display("FAIL full_pop_data: got %0h exp 11", tl_h1_o.d_data); end
        checks++; if (tl_h0_o.d_valid !== 1'b0) begin errors++; $display("FAIL full_pop_h0_dvalid: got %0b exp 0", tl_h0_o.d_valid); end
        checks++; if (tl_h0_o.a_ready !== 1'b0) begin errors++; $display("FAIL full_pop_h0_aready: got %0b exp 0", tl_h0_o.a_ready); end
        step();
        tl_d_i = '0;
        tl_d_i.a_ready = 1'b1;
        #1;
        checks++; if (outstanding_o !== 2'd1) begin errors++; $display("FAIL full_resume_out: got %0d exp 1", outstanding_o); end
        checks++; if (tl_d_o.a_valid !== 1'b1) begin errors++; $display("FAIL full_resume_avalid: got %0b exp 1", tl_d_o.a_valid); end
        checks++; if (tl_d_o.a_address !== 32'h300) begin errors++; $display("FAIL full_resume_addr: got %0h exp 300", tl_d_o.a_address); end
        step();
        checks++; if (outstanding_o !== 2'd2) begin errors++; $display("FAIL full_after_out: got %0d exp 2", outstanding_o); end
    endtask

    task automatic test_in_order();
        do_reset();
        tl_h1_i = req(32'h1000, 8'd1);
        step();
        tl_h1_i = '0;
        tl_h1_i.d_ready = 1'b1;
        tl_h0_i = req(32'h84, 8'd0);
        step();
        idle();
        tl_d_i = rsp(32'hAA);
        #1;
        checks++; if (tl_h1_o.d_valid !== 1'b1 || tl_h1_o.d_data !== 32'hAA) begin errors++; $display("FAIL order_first_h1: got v=%0b d=%0h exp v=1 d=aa", tl_h1_o.d_valid, tl_h1_o.d_data); end
        checks++; if (tl_h0_o.d_valid !== 1'b0) begin errors++; $display("FAIL order_first_h0: got %0b exp 0", tl_h0_o.d_valid); end
        step();
        tl_d_i = rsp(32'hBB);
        #1;
        checks++; if (tl_h0_o.d_valid !== 1'b1 || tl_h0_o.d_data !== 32'hBB) begin errors++; $display("FAIL order_second_h0: got v=%0b d=%0h exp v=1 d=bb", tl_h0_o.d_valid, tl_h0_o.d_data); end
        checks++; if (tl_h1_o.d_valid !== 1'b0) begin errors++; $display("FAIL order_second_h1: got %0b exp 0", tl_h1_o.d_valid); end
        step();
        idle();
        #1;
        checks++; if (outstanding_o !== 2'd0) begin errors++; $display("FAIL order_out: got %0d exp 0", outstanding_o); end
    endtask

    task automatic test_unexpected_reset();
        do_reset();
        tl_d_i = rsp(32'h55);
        #1;
        checks++; if (tl_d_o.d_ready !== 1'b1) begin errors++; $display("FAIL unexp_dready: got %0b exp 1", tl_d_o.d_ready); end
        checks++; if (tl_h0_o.d_valid !== 1'b0 || tl_h1_o.d_valid !== 1'b0) begin errors++; $display("FAIL unexp_dvalid: got %0b/%0b exp 0/0", tl_h0_o.d_valid, tl_h1_o.d_valid); end
        step();
        idle();
        #1;
        checks++; if (unexp_rsp_o !== 1'b1) begin errors++; $display("FAIL unexp_set: got %0b exp 1", unexp_rsp_o); end
        tl_h0_i = req(32'h10, 8'd0);
        step();
        tl_h0_i = '0;
        tl_h0_i.d_ready = 1'b1;
        tl_h1_i = req(32'h20, 8'd1);
        step();
        tl_h1_i = '0;
        tl_h1_i.d_ready = 1'b1;
        #1;
        checks++; if (unexp_rsp_o !== 1'b1) begin errors++; $display("FAIL unexp_sticky: got %0b exp 1", unexp_rsp_o); end
        checks++; if (outstanding_o !== 2'd2) begin errors++; $display("FAIL unexp_pre_out: got %0d exp 2", outstanding_o); end
        rst_ni = 1'b0;
        #1;
        checks++; if (outstanding_o !== 2'd0) begin errors++; $display("FAIL unexp_async_out: got %0d exp 0", outstanding_o); end
        checks++; if (unexp_rsp_o !== 1'b0) begin errors++; $display("FAIL unexp_async_clr: got %0b exp 0", unexp_rsp_o); end
        step();
        rst_ni = 1'b1;
        #1;
        tl_d_i = rsp(32'h66);
        #1;
        checks++; if (tl_h0_o.d_valid !== 1'b0 || tl_d_o.d_ready !== 1'b1) begin errors++; $display("FAIL unexp_late_drain: got v=%0b rdy=%0b exp v=0 rdy=1", tl_h0_o.d_valid, tl_d_o.d_ready); end
        step();
        idle();
        #1;
        checks++; if (unexp_rsp_o !== 1'b1) begin errors++; $display("FAIL unexp_late_flag: got %0b exp 1", unexp_rsp_o); end
    endtask

    task automatic test_random();
        int          q[$];
        int          last = 1;
        int          hold = -1;
        bit          unexp = 1'b0;
        bit          pend[2];
        logic [31:0] addr[2];
        int          g;
        bit          gv, ev, empty, edr, e0dv, e1dv, push, pop, dev_ar, dv, prio;
        int          head;
        logic [31:0] data;
`ifdef TLUL_HOST_ARB_DATA_PRIO_EN
        prio = 1'b1;
`else
        prio = 1'b0;
`endif
        pend = '{1'b0, 1'b0};
        addr = '{32'h0, 32'h0};
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int h = 0; h < 2; h++) begin
                if (!pend[h] && $urandom_range(2) == 0) begin
                    pend[h] = 1'b1;
                    addr[h] = $urandom & 32'hffff_fffc;
                end
            end
            if (pend[0]) tl_h0_i = req(addr[0], 8'd0); else tl_h0_i = '0;
            if (pend[1]) tl_h1_i = req(addr[1], 8'd1); else tl_h1_i = '0;
            tl_h0_i.d_ready = ($urandom_range(3) != 0);
            tl_h1_i.d_ready = ($urandom_range(3) != 0);
            dev_ar = ($urandom_range(3) != 0);
            dv     = ($urandom_range(1) == 1);
            data   = $urandom;
            tl_d_i = '0;
            tl_d_i.a_ready  = dev_ar;
            tl_d_i.d_valid  = dv;
            tl_d_i.d_opcode = OpAccessAckData;
            tl_d_i.d_data   = data;

            if (hold >= 0) g = hold;
            else if (pend[0] && pend[1]) g = prio ? 1 : 1 - last;
            else g = pend[1] ? 1 : 0;
            gv    = pend[g];
            ev    = gv && (q.size() < Depth);
            empty = (q.size() == 0);
            head  = empty ? 0 : q[0];
            edr   = empty ? 1'b1 : (head == 1 ? tl_h1_i.d_ready : tl_h0_i.d_ready);
            e0dv  = !empty && head == 0 && dv;
            e1dv  = !empty && head == 1 && dv;
            #1;
            checks++; if (tl_d_o.a_valid !== ev) begin errors++; $display("FAIL rnd_avalid c%0d: got %0b exp %0b", c, tl_d_o.a_valid, ev); end
            if (ev) begin
                checks++; if (tl_d_o.a_address !== addr[g]) begin errors++; $display("FAIL rnd_addr c%0d: got %0h exp %0h", c, tl_d_o.a_address, addr[g]); end
            end
            if (pend[0]) begin
                checks++; if (tl_h0_o.a_ready !== (g == 0 && dev_ar && q.size() < Depth)) begin errors++; $display("FAIL rnd_h0_aready c%0d: got %0b", c, tl_h0_o.a_ready); end
            end
            if (pend[1]) begin
                checks++; if (tl_h1_o.a_ready !== (g == 1 && dev_ar && q.size() < Depth)) begin errors++; $display("FAIL rnd_h1_aready c%0d: got %0b", c, tl_h1_o.a_ready); end
            end
            checks++; if (tl_d_o.d_ready !== edr) begin errors++; $display("FAIL rnd_dready c%0d: got %0b exp %0b", c, tl_d_o.d_ready, edr); end
            checks++; if (tl_h0_o.d_valid !== e0dv || tl_h1_o.d_valid !== e1dv) begin errors++; $display("FAIL rnd_dvalid c%0d: got %0b/%0b exp %0b/%0b", c, tl_h0_o.d_valid, tl_h1_o.d_valid, e0dv, e1dv); end
            if (e0dv) begin
                checks++; if (tl_h0_o.d_data !== data) begin errors++; $display("FAIL rnd_h0_data c%0d: got %0h exp %0h", c, tl_h0_o.d_data, data); end
            end
            if (e1dv) begin
                checks++; if (tl_h1_o.d_data !== data) begin errors++; $display("FAIL rnd_h1_data c%0d: got %0h exp %0h", c, tl_h1_o.d_data, data); end
            end

            push = ev && dev_ar;
            pop  = !empty && dv && edr;
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back(g);
                last    = g;
                pend[g] = 1'b0;
                hold    = -1;
            end else if (gv) begin
                hold = g;
            end
            if (empty && dv) unexp = 1'b1;
            step();
            checks++; if (outstanding_o !== CntW'(q.size())) begin errors++; $display("FAIL rnd_out c%0d: got %0d exp %0d", c, outstanding_o, q.size()); end
            checks++; if (unexp_rsp_o !== unexp) begin errors++; $display("FAIL rnd_unexp c%0d: got %0b exp %0b", c, unexp_rsp_o, unexp); end
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_single_host();
        test_contention();
        test_stall_lock();
        test_full();
        test_in_order();
        test_unexpected_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
